// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Assembles fixed-length host command frames from the UART receiver byte
// stream and hands each decoded command to the analyzer control logic.
//
// Frame layout (7 bytes, one per i_Rx_DV strobe):
//     SYNC, OPCODE, ARG[31:24], ARG[23:16], ARG[15:8], ARG[7:0], CHK
// CHK must equal OPCODE ^ ARG[31:24] ^ ARG[23:16] ^ ARG[15:8] ^ ARG[7:0].
//
// Ports:
//     i_Clock       system clock, rising edge
//     i_Reset       synchronous active-high reset
//     i_Rx_DV       one-cycle byte strobe from the UART receiver
//     i_Rx_Byte     received byte, meaningful only while i_Rx_DV=1
//     i_Cmd_Ready   consumer accepts the presented command
//     o_Cmd_Valid   decoded command available (held until accepted)
//     o_Cmd_Opcode  command opcode
//     o_Cmd_Arg     command argument, MSB byte received first
//     o_Err         one-cycle error pulse
//     o_Err_Code    error cause while o_Err=1: 01 checksum, 10 timeout,
//                   11 overrun (byte arrived while a command was pending)
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 100000
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    input  logic        i_Cmd_Ready,
    output logic        o_Cmd_Valid,
    output logic [7:0]  o_Cmd_Opcode,
    output logic [31:0] o_Cmd_Arg,
    output logic        o_Err,
    output logic [1:0]  o_Err_Code
);

    // Inter-byte idle counter width; the counter never needs to exceed
    // TIMEOUT_CLKS-1 because the frame is abandoned at that value.
    localparam int unsigned CNT_W = (TIMEOUT_CLKS > 32'd1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CLKS - 32'd1);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CHK  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_OVR  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPCODE = 3'd1,
        ST_ARG    = 3'd2,
        ST_CHK    = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Running XOR checksum step.
    function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        acc_r;
    logic [7:0]        acc_nxt_s;
    logic [1:0]        idx_r;
    logic [1:0]        idx_nxt_s;
    logic [CNT_W-1:0]  tmo_cnt_r;
    logic [CNT_W-1:0]  tmo_cnt_nxt_s;
    logic [7:0]        opcode_r;
    logic [7:0]        opcode_nxt_s;
    logic [31:0]       arg_r;
    logic [31:0]       arg_nxt_s;

    logic              cmd_valid_nxt_s;
    logic [7:0]        cmd_opcode_nxt_s;
    logic [31:0]       cmd_arg_nxt_s;
    logic              err_nxt_s;
    logic [1:0]        err_code_nxt_s;

    logic              sync_s;
    logic              in_frame_s;
    logic              tmo_hit_s;
    logic              chk_ok_s;

    assign sync_s     = i_Rx_DV && (i_Rx_Byte == SYNC_BYTE);
    assign in_frame_s = (state_r == ST_OPCODE) || (state_r == ST_ARG) || (state_r == ST_CHK);
    // A byte in the boundary cycle wins over the timeout.
    assign tmo_hit_s  = in_frame_s && !i_Rx_DV && (tmo_cnt_r == TMO_LAST);
    assign chk_ok_s   = (i_Rx_Byte == acc_r);

    // State, datapath and output registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_r      <= ST_IDLE;
            acc_r        <= 8'h00;
            idx_r        <= 2'd0;
            tmo_cnt_r    <= '0;
            opcode_r     <= 8'h00;
            arg_r        <= 32'h0000_0000;
            o_Cmd_Valid  <= 1'b0;
            o_Cmd_Opcode <= 8'h00;
            o_Cmd_Arg    <= 32'h0000_0000;
            o_Err        <= 1'b0;
            o_Err_Code   <= ERR_NONE;
        end else begin
            state_r      <= state_nxt_s;
            acc_r        <= acc_nxt_s;
            idx_r        <= idx_nxt_s;
            tmo_cnt_r    <= tmo_cnt_nxt_s;
            opcode_r     <= opcode_nxt_s;
            arg_r        <= arg_nxt_s;
            o_Cmd_Valid  <= cmd_valid_nxt_s;
            o_Cmd_Opcode <= cmd_opcode_nxt_s;
            o_Cmd_Arg    <= cmd_arg_nxt_s;
            o_Err        <= err_nxt_s;
            o_Err_Code   <= err_code_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sync_s) begin
                    state_nxt_s = ST_OPCODE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OPCODE: begin
                if (i_Rx_DV) begin
                    state_nxt_s = ST_ARG;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_OPCODE;
                end
            end
            ST_ARG: begin
                if (i_Rx_DV) begin
                    if (idx_r == 2'd3) begin
                        state_nxt_s = ST_CHK;
                    end else begin
                        state_nxt_s = ST_ARG;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ARG;
                end
            end
            ST_CHK: begin
                if (i_Rx_DV) begin
                    if (chk_ok_s) begin
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CHK;
                end
            end
            ST_HOLD: begin
                // Acceptance frees the parser in the same cycle, so a SYNC
                // arriving alongside ready starts the next frame at once.
                if (i_Cmd_Ready) begin
                    if (sync_s) begin
                        state_nxt_s = ST_OPCODE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath, timeout counter and registered-output next values.
    always_comb begin
        acc_nxt_s        = acc_r;
        idx_nxt_s        = idx_r;
        opcode_nxt_s     = opcode_r;
        arg_nxt_s        = arg_r;
        cmd_valid_nxt_s  = o_Cmd_Valid;
        cmd_opcode_nxt_s = o_Cmd_Opcode;
        cmd_arg_nxt_s    = o_Cmd_Arg;
        err_nxt_s        = 1'b0;
        err_code_nxt_s   = ERR_NONE;

        // Idle-gap counter only runs inside a frame; it restarts on every
        // byte and saturates at the terminal count.
        if (in_frame_s) begin
            if (i_Rx_DV || tmo_hit_s) begin
                tmo_cnt_nxt_s = '0;
            end else if (tmo_cnt_r != TMO_LAST) begin
                tmo_cnt_nxt_s = tmo_cnt_r + CNT_W'(1'b1);
            end else begin
                tmo_cnt_nxt_s = tmo_cnt_r;
            end
        end else begin
            tmo_cnt_nxt_s = '0;
        end

        case (state_r)
            ST_IDLE: begin
                if (sync_s) begin
                    acc_nxt_s = 8'h00;
                end else begin
                    acc_nxt_s = acc_r;
                end
            end
            ST_OPCODE: begin
                if (i_Rx_DV) begin
                    opcode_nxt_s = i_Rx_Byte;
                    acc_nxt_s    = i_Rx_Byte;
                    idx_nxt_s    = 2'd0;
                end else if (tmo_hit_s) begin
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = ERR_TMO;
                end else begin
                    err_nxt_s = 1'b0;
                end
            end
            ST_ARG: begin
                if (i_Rx_DV) begin
                    arg_nxt_s = {arg_r[23:0], i_Rx_Byte};
                    acc_nxt_s = xor_acc(acc_r, i_Rx_Byte);
                    idx_nxt_s = idx_r + 2'd1;
                end else if (tmo_hit_s) begin
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = ERR_TMO;
                end else begin
                    err_nxt_s = 1'b0;
                end
            end
            ST_CHK: begin
                if (i_Rx_DV) begin
                    // Outputs are only touched by a frame that checks out.
                    if (chk_ok_s) begin
                        cmd_valid_nxt_s  = 1'b1;
                        cmd_opcode_nxt_s = opcode_r;
                        cmd_arg_nxt_s    = arg_r;
                    end else begin
                        err_nxt_s      = 1'b1;
                        err_code_nxt_s = ERR_CHK;
                    end
                end else if (tmo_hit_s) begin
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = ERR_TMO;
                end else begin
                    err_nxt_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (i_Cmd_Ready) begin
                    cmd_valid_nxt_s = 1'b0;
                    if (sync_s) begin
                        acc_nxt_s = 8'h00;
                    end else begin
                        acc_nxt_s = acc_r;
                    end
                end else if (i_Rx_DV) begin
                    // Byte is dropped; the pending command stays intact.
                    err_nxt_s      = 1'b1;
                    err_code_nxt_s = ERR_OVR;
                end else begin
                    err_nxt_s = 1'b0;
                end
            end
            default: begin
                cmd_valid_nxt_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TMO  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv;
    logic [7:0]  rx_byte;
    logic        ready;
    logic        cmd_valid;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_arg;
    logic        err;
    logic [1:0]  err_code;

    uart_cmd_parser #(
        .SYNC_BYTE    (SYNC),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .i_Clock      (clk),
        .i_Reset      (rst),
        .i_Rx_DV      (dv),
        .i_Rx_Byte    (rx_byte),
        .i_Cmd_Ready  (ready),
        .o_Cmd_Valid  (cmd_valid),
        .o_Cmd_Opcode (cmd_opcode),
        .o_Cmd_Arg    (cmd_arg),
        .o_Err        (err),
        .o_Err_Code   (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {int due; logic [1:0] code;} err_ev_t;
    typedef struct {int due; logic [7:0] op; logic [31:0] arg;} cmd_ev_t;

    err_ev_t err_q[$];
    cmd_ev_t cmd_q[$];

    // Reference model state: bytes of the frame collected so far, whether a
    // decoded command is waiting for the consumer, and the silent-cycle gap.
    logic [7:0] frm[$];
    bit         pending = 1'b0;
    int         gap = 0;

    bit         mon_en = 1'b0;
    bit         exp_v = 1'b0;
    cmd_ev_t    cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_err(input logic [1:0] code);
        err_ev_t e;
        e.due  = cyc + 1;
        e.code = code;
        err_q.push_back(e);
    endtask

    task automatic push_cmd(input logic [7:0] op, input logic [31:0] arg);
        cmd_ev_t c;
        c.due = cyc + 1;
        c.op  = op;
        c.arg = arg;
        cmd_q.push_back(c);
    endtask

    // Model: predicts the events the parser reports after this cycle's edge.
    task automatic model_step(input bit v, input logic [7:0] b, input bit r, input bit rs);
        logic [7:0] x;
        if (rs) begin
            frm.delete();
            pending = 1'b0;
            gap = 0;
        end else if (pending) begin
            if (r) begin
                pending = 1'b0;
                if (v && b == SYNC) begin
                    frm.delete();
                    frm.push_back(b);
                    gap = 0;
                end
            end else if (v) begin
                push_err(2'b11);
            end
        end else if (frm.size() > 0) begin
            if (v) begin
                frm.push_back(b);
                gap = 0;
                if (frm.size() == 7) begin
                    x = frm[1] ^ frm[2] ^ frm[3] ^ frm[4] ^ frm[5];
                    if (x == frm[6]) begin
                        push_cmd(frm[1], {frm[2], frm[3], frm[4], frm[5]});
                        pending = 1'b1;
                    end else begin
                        push_err(2'b01);
                    end
                    frm.delete();
                end
            end else begin
                gap++;
                if (gap == TMO) begin
                    push_err(2'b10);
                    frm.delete();
                end
            end
        end else if (v && b == SYNC) begin
            frm.push_back(b);
            gap = 0;
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge.
    task automatic step(input bit v, input logic [7:0] b, input bit r, input bit rs);
        dv      = v;
        rx_byte = v ? b : 8'($urandom);
        ready   = r;
        rst     = rs;
        model_step(v, b, r, rs);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit r, input bit rnd_r);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 8'h00, rnd_r ? 1'($urandom_range(0, 1)) : r, 1'b0);
        end
    endtask

    // Sends a frame; delta corrupts the checksum when non-zero. In random
    // mode the inter-byte gaps and ready are randomised, including gaps that
    // land exactly on and just past the timeout boundary.
    task automatic frame(input logic [7:0] op, input logic [31:0] arg, input logic [7:0] delta,
                         input bit r, input bit with_sync, input bit rnd);
        logic [7:0] fb[7];
        int         g;
        int         sel;
        fb[0] = SYNC;
        fb[1] = op;
        fb[2] = arg[31:24];
        fb[3] = arg[23:16];
        fb[4] = arg[15:8];
        fb[5] = arg[7:0];
        fb[6] = op ^ arg[31:24] ^ arg[23:16] ^ arg[15:8] ^ arg[7:0] ^ delta;
        for (int j = (with_sync ? 0 : 1); j < 7; j++) begin
            if (rnd && j > 0) begin
                sel = int'($urandom_range(0, 19));
                if (sel < 14)       g = 0;
                else if (sel < 17)  g = int'($urandom_range(1, 5));
                else if (sel == 17) g = TMO - 1;
                else if (sel == 18) g = TMO;
                else                g = int'($urandom_range(6, 20));
                idle(g, 1'b0, 1'b1);
            end
            step(1'b1, fb[j], rnd ? 1'($urandom_range(0, 1)) : r, 1'b0);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues each cycle.
    always @(negedge clk) begin
        bit         exp_e;
        logic [1:0] exp_code;
        if (mon_en) begin
            exp_e = 1'b0;
            exp_code = 2'b00;
            while (err_q.size() > 0 && err_q[0].due < cyc) begin
                check("err_missed", 64'd0, 64'd1);
                void'(err_q.pop_front());
            end
            if (err_q.size() > 0 && err_q[0].due == cyc) begin
                exp_e = 1'b1;
                exp_code = err_q[0].code;
                void'(err_q.pop_front());
            end
            if (err || exp_e) begin
                check("err", 64'(err), 64'(exp_e));
                check("err_code", 64'(err_code), 64'(exp_code));
            end
            while (cmd_q.size() > 0 && cmd_q[0].due < cyc) begin
                check("cmd_missed", 64'd0, 64'd1);
                void'(cmd_q.pop_front());
            end
            if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
                cur = cmd_q.pop_front();
                exp_v = 1'b1;
            end
            if (cmd_valid || exp_v) begin
                check("cmd_valid", 64'(cmd_valid), 64'(exp_v));
                if (exp_v) begin
                    check("cmd_opcode", 64'(cmd_opcode), 64'(cur.op));
                    check("cmd_arg", 64'(cmd_arg), 64'(cur.arg));
                end
            end
            if (exp_v && ready) exp_v = 1'b0;
            if (rst) exp_v = 1'b0;
        end
    end

    initial begin
        int kind;
        int nb;
        logic [7:0] delta;

        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        check("rst_opcode", 64'(cmd_opcode), 64'd0);
        check("rst_arg", 64'(cmd_arg), 64'd0);
        mon_en = 1'b1;

        // Good frame, consumer stalls 10 cycles then accepts.
        frame(8'h01, 32'h12345678, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(10, 1'b0, 1'b0);
        idle(1, 1'b1, 1'b0);
        idle(3, 1'b0, 1'b0);

        // Bad checksum (0A instead of 09), then a good frame.
        frame(8'h01, 32'h12345678, 8'h03, 1'b1, 1'b1, 1'b0);
        idle(2, 1'b1, 1'b0);
        frame(8'h42, 32'hDEADBEEF, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);

        // Timeout after A5 02, then a byte landing exactly on the boundary.
        step(1'b1, SYNC, 1'b1, 1'b0);
        step(1'b1, 8'h02, 1'b1, 1'b0);
        idle(TMO + 4, 1'b1, 1'b0);
        step(1'b1, SYNC, 1'b1, 1'b0);
        step(1'b1, 8'h02, 1'b1, 1'b0);
        idle(TMO - 1, 1'b1, 1'b0);
        step(1'b1, 8'h11, 1'b1, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b1, 1'b0);
        step(1'b1, 8'h44, 1'b1, 1'b0);
        step(1'b1, 8'h02 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);

        // Overrun while pending, then SYNC together with ready.
        frame(8'h01, 32'h12345678, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        step(1'b1, SYNC, 1'b1, 1'b0);
        frame(8'h05, 32'hCAFEF00D, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1, 1'b0);

        // Garbage, partial frame, reset, then a good frame.
        step(1'b1, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b1, SYNC, 1'b1, 1'b0);
        step(1'b1, 8'h07, 1'b1, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        frame(8'h3C, 32'h0BADF00D, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);

        // Back-to-back frames with ready tied high.
        frame(8'h11, 32'h01020304, 8'h00, 1'b1, 1'b1, 1'b0);
        frame(8'h22, 32'hA5A5A5A5, 8'h00, 1'b1, 1'b1, 1'b0);
        idle(3, 1'b1, 1'b0);

        // Randomised traffic.
        for (int i = 0; i < 150; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            end else if (kind == 1) begin
                nb = int'($urandom_range(1, 6));
                step(1'b1, SYNC, 1'($urandom_range(0, 1)), 1'b0);
                for (int k = 1; k < nb; k++) begin
                    step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
                end
                idle(TMO + int'($urandom_range(0, 3)), 1'b0, 1'b1);
            end else begin
                delta = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
                frame(8'($urandom), $urandom, delta, 1'b0, 1'b1, 1'b1);
            end
            idle(int'($urandom_range(0, 4)), 1'b0, 1'b1);
        end

        idle(20, 1'b1, 1'b0);
        mon_en = 1'b0;
        check("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
        check("err_queue_drained", 64'(err_q.size()), 64'd0);
        check("valid_outstanding", 64'(exp_v), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
